// File: rtl/ps2_host_tx_pkg.sv
// -----------------------------------------------------------------------------
// ps2_host_tx_pkg
// Shared definitions for the PS/2 host-to-device transmitter:
//   - FSM state encoding
//   - err_code values reported on completion
//   - 25 MHz timing defaults
//   - odd-parity helper and a small max helper used for counter sizing
// -----------------------------------------------------------------------------
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_REQ      = 3'd2,
    ST_WAIT_CLK = 3'd3,
    ST_SEND     = 3'd4,
    ST_ACK_IDLE = 3'd5,
    ST_FAIL     = 3'd6
  } ps2_state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_START_TO = 2'b01;
  localparam logic [1:0] ERR_XFER_TO  = 2'b10;
  localparam logic [1:0] ERR_NO_ACK   = 2'b11;

  // Defaults for a 25 MHz clock.
  localparam int unsigned DEF_INHIBIT_CYCLES       = 32'd3000;
  localparam int unsigned DEF_REQ_CYCLES           = 32'd16;
  localparam int unsigned DEF_START_TIMEOUT_CYCLES = 32'd375000;
  localparam int unsigned DEF_XFER_TIMEOUT_CYCLES  = 32'd50000;
  localparam int unsigned DEF_FILTER_LEN           = 32'd8;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_host_tx_line_filter
// Synchronises an asynchronous PS/2 pad input (2 FFs), then debounces it: the
// filtered level only changes after FILTER_LEN consecutive samples disagree
// with it. o_fall pulses for one cycle together with a 1->0 filtered change.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (filtered level resets to 1)
//   i_pad    raw pad input
//   o_level  filtered line level
//   o_fall   one-cycle pulse on filtered falling edge
// -----------------------------------------------------------------------------
module ps2_host_tx_line_filter #(
  parameter int unsigned FILTER_LEN = 32'd8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pad,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Synchroniser, disagreement counter and filtered level/fall registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_sync <= {r_sync[0], i_pad};
      if (r_sync[1] == r_level) begin
        r_cnt  <= {CW{1'b0}};
        r_fall <= 1'b0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        // FILTER_LEN-th disagreeing sample in a row: adopt the new level.
        r_level <= r_sync[1];
        r_cnt   <= {CW{1'b0}};
        r_fall  <= r_level;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_fall <= 1'b0;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Inhibits the bus, issues a request-to-send,
// then shifts out data (LSB first), odd parity and stop on device clock falls
// and checks the device ACK. Pins are open-drain: *_oe = 1 pulls the line low.
// Ports:
//   CLK, nRESET        system clock, asynchronous active-low reset
//   tx_data, tx_valid  byte to send and request (accepted when tx_ready)
//   tx_ready           high only in IDLE
//   busy               transfer in progress
//   done, err          one-cycle completion pulse / failure flag with it
//   err_code           00 ok, 01 start timeout, 10 xfer timeout, 11 no ACK
//   ps2_clk_in/_data_in  asynchronous pad inputs
//   ps2_clk_oe/_data_oe  open-drain pull-low enables
// -----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
  parameter int unsigned REQ_CYCLES           = DEF_REQ_CYCLES,
  parameter int unsigned START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = DEF_XFER_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_LEN           = DEF_FILTER_LEN
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned T_MAX =
    max_u(max_u(INHIBIT_CYCLES, REQ_CYCLES), max_u(START_TIMEOUT_CYCLES, XFER_TIMEOUT_CYCLES));
  localparam int TW = $clog2(T_MAX + 1);

  ps2_state_e r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_bitcnt, w_bitcnt_next;
  logic [8:0]    r_frame;
  logic          w_timer_clr, w_accept, w_done, w_err, w_tx_bit;
  logic          w_clk_oe_next, w_data_oe_next;
  logic [1:0]    w_err_code_next;
  logic          w_clk_lvl, w_clk_fall, w_data_lvl, w_data_fall;
  logic          r_tx_ready, r_busy, r_done, r_err, r_clk_oe, r_data_oe;
  logic [1:0]    r_err_code;
  logic          w_inh_end, w_req_end, w_start_to, w_xfer_to;

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .i_clk(CLK), .i_rst_n(nRESET), .i_pad(ps2_clk_in),
    .o_level(w_clk_lvl), .o_fall(w_clk_fall)
  );

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .i_clk(CLK), .i_rst_n(nRESET), .i_pad(ps2_data_in),
    .o_level(w_data_lvl), .o_fall(w_data_fall)
  );

  // Timer counts cycles since the last clear; >= keeps a saturated timer expired.
  assign w_inh_end  = (r_timer >= TW'(INHIBIT_CYCLES - 1));
  assign w_req_end  = (r_timer >= TW'(REQ_CYCLES - 1));
  assign w_start_to = (r_timer >= TW'(START_TIMEOUT_CYCLES - 1));
  assign w_xfer_to  = (r_timer >= TW'(XFER_TIMEOUT_CYCLES - 1));

  // Next-state, timer control and completion signalling.
  always_comb begin
    w_next          = r_state;
    w_timer_clr     = 1'b0;
    w_bitcnt_next   = r_bitcnt;
    w_accept        = 1'b0;
    w_done          = 1'b0;
    w_err           = 1'b0;
    w_err_code_next = r_err_code;
    case (r_state)
      ST_IDLE: begin
        if (tx_valid) begin
          w_accept        = 1'b1;
          w_next          = ST_INHIBIT;
          w_timer_clr     = 1'b1;
          w_err_code_next = ERR_OK;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (w_inh_end) begin
          w_next      = ST_REQ;
          w_timer_clr = 1'b1;
        end else begin
          w_next = ST_INHIBIT;
        end
      end
      ST_REQ: begin
        if (w_req_end) begin
          w_next      = ST_WAIT_CLK;
          w_timer_clr = 1'b1;
        end else begin
          w_next = ST_REQ;
        end
      end
      ST_WAIT_CLK: begin
        if (w_start_to) begin
          w_next          = ST_FAIL;
          w_err_code_next = ERR_START_TO;
        end else if (w_clk_fall) begin
          // Transfer timer measures from this first device fall.
          w_next        = ST_SEND;
          w_bitcnt_next = 4'd0;
          w_timer_clr   = 1'b1;
        end else begin
          w_next = ST_WAIT_CLK;
        end
      end
      ST_SEND: begin
        if (w_xfer_to) begin
          w_next          = ST_FAIL;
          w_err_code_next = ERR_XFER_TO;
        end else if (w_clk_fall) begin
          if (r_bitcnt == 4'd10) begin
            if (!w_data_lvl) begin
              w_next = ST_ACK_IDLE;
            end else begin
              w_next          = ST_FAIL;
              w_err_code_next = ERR_NO_ACK;
            end
          end else begin
            w_bitcnt_next = r_bitcnt + 4'd1;
          end
        end else begin
          w_next = ST_SEND;
        end
      end
      ST_ACK_IDLE: begin
        if (w_xfer_to) begin
          w_next          = ST_FAIL;
          w_err_code_next = ERR_XFER_TO;
        end else if (w_clk_lvl && w_data_lvl) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end else begin
          w_next = ST_ACK_IDLE;
        end
      end
      ST_FAIL: begin
        w_next = ST_IDLE;
        w_done = 1'b1;
        w_err  = 1'b1;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Pin drive for the upcoming state; bitcnt 0 keeps the start bit, 10 is stop.
  always_comb begin
    w_tx_bit = 1'b1;
    case (w_bitcnt_next)
      4'd0:    w_tx_bit = 1'b0;
      4'd10:   w_tx_bit = 1'b1;
      default: begin
        if (w_bitcnt_next <= 4'd9) begin
          w_tx_bit = r_frame[w_bitcnt_next - 4'd1];
        end else begin
          w_tx_bit = 1'b1;
        end
      end
    endcase
    w_clk_oe_next  = (w_next == ST_INHIBIT) || (w_next == ST_REQ);
    w_data_oe_next = (w_next == ST_REQ) || (w_next == ST_WAIT_CLK) ||
                     ((w_next == ST_SEND) && !w_tx_bit);
  end

  // FSM state, shared saturating timer, bit counter and frame latch.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state  <= ST_IDLE;
      r_timer  <= {TW{1'b0}};
      r_bitcnt <= 4'd0;
      r_frame  <= 9'd0;
    end else begin
      r_state  <= w_next;
      r_bitcnt <= w_bitcnt_next;
      if (w_timer_clr) begin
        r_timer <= {TW{1'b0}};
      end else if (r_timer != {TW{1'b1}}) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= r_timer;
      end
      if (w_accept) begin
        r_frame <= {odd_parity(tx_data), tx_data};
      end else begin
        r_frame <= r_frame;
      end
    end
  end

  // Registered outputs; reset releases both pins immediately.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_OK;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
    end else begin
      r_tx_ready <= (w_next == ST_IDLE);
      r_busy     <= (w_next != ST_IDLE);
      r_done     <= w_done;
      r_err      <= w_err;
      r_err_code <= w_err_code_next;
      r_clk_oe   <= w_clk_oe_next;
      r_data_oe  <= w_data_oe_next;
    end
  end

  assign tx_ready    = r_tx_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

  // The data line is only ever sampled as a level; its fall pulse is not needed.
  logic w_unused;
  assign w_unused = w_data_fall;

endmodule
